// File: rtl/f3_offset_ram_if.sv
// Command and read-port bundle for the tile offset RAM.
// The master issues row/column rotate commands and reads back per-cell offsets.
`timescale 1ns/1ps
interface f3_offset_ram_if #(
  parameter int GRID_BITS = 4
);
  logic                 ram_write;
  logic [GRID_BITS-1:0] ram_write_pos;
  logic                 ram_write_horizontal;
  logic                 ram_write_increase;
  logic                 ram_reset;
  logic [GRID_BITS-1:0] offset_pos_x;
  logic [GRID_BITS-1:0] offset_pos_y;
  logic [GRID_BITS-1:0] offset_x;
  logic [GRID_BITS-1:0] offset_y;
  logic                 offset_all_zero;
  logic                 busy;

  modport master (
    output ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
    output ram_reset, offset_pos_x, offset_pos_y,
    input  offset_x, offset_y, offset_all_zero, busy
  );

  modport slave (
    input  ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
    input  ram_reset, offset_pos_x, offset_pos_y,
    output offset_x, offset_y, offset_all_zero, busy
  );
endinterface

// File: rtl/f3_offset_ram.sv
// Per-cell H/V offset grid with single-edge row/column rotate-and-bump commands.
// Combinational read port; all-zero flag refreshed one edge after each shift.
`timescale 1ns/1ps
module f3_offset_ram #(
  parameter int GRID_BITS = 4
) (
  input logic          sysclk,
  input logic          reset_n,
  f3_offset_ram_if.slave bus
);
  localparam int N = 1 << GRID_BITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FLAG} state_t;

  state_t               state_reg;
  logic [GRID_BITS-1:0] cmd_pos_reg;
  logic                 cmd_horizontal_reg;
  logic                 cmd_increase_reg;
  logic                 busy_reg;
  logic                 all_zero_reg;

  logic [GRID_BITS-1:0] h_reg [N][N];
  logic [GRID_BITS-1:0] v_reg [N][N];
  logic [N*N-1:0]       cell_nonzero;

  // Command sequencer; ram_reset overrides everything, including a pending ram_write.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      cmd_pos_reg        <= '0;
      cmd_horizontal_reg <= 1'b0;
      cmd_increase_reg   <= 1'b0;
      busy_reg           <= 1'b0;
      all_zero_reg       <= 1'b1;
    end else if (bus.ram_reset) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      all_zero_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ram_write) begin
            cmd_pos_reg        <= bus.ram_write_pos;
            cmd_horizontal_reg <= bus.ram_write_horizontal;
            cmd_increase_reg   <= bus.ram_write_increase;
            state_reg          <= SHIFT;
            busy_reg           <= 1'b1;
          end
        end
        SHIFT: begin
          state_reg <= FLAG;
        end
        FLAG: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          all_zero_reg <= ~|cell_nonzero;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    for (genvar gj = 0; gj < N; gj++) begin : g_row
      // Wrapped neighbour indices are elaboration-time constants per cell.
      localparam int C_UP = (gi + 1) % N;
      localparam int C_DN = (gi + N - 1) % N;
      localparam int R_UP = (gj + 1) % N;
      localparam int R_DN = (gj + N - 1) % N;

      logic                 in_row;
      logic                 in_col;
      logic [GRID_BITS-1:0] h_next;
      logic [GRID_BITS-1:0] v_next;

      assign in_row = cmd_horizontal_reg && (cmd_pos_reg == GRID_BITS'(gj));
      assign in_col = !cmd_horizontal_reg && (cmd_pos_reg == GRID_BITS'(gi));

      always_comb begin
        h_next = h_reg[gi][gj];
        v_next = v_reg[gi][gj];
        if (in_row) begin
          if (cmd_increase_reg) begin
            h_next = h_reg[C_UP][gj] + GRID_BITS'(1);
            v_next = v_reg[C_UP][gj];
          end else begin
            h_next = h_reg[C_DN][gj] - GRID_BITS'(1);
            v_next = v_reg[C_DN][gj];
          end
        end else if (in_col) begin
          if (cmd_increase_reg) begin
            v_next = v_reg[gi][R_UP] + GRID_BITS'(1);
            h_next = h_reg[gi][R_UP];
          end else begin
            v_next = v_reg[gi][R_DN] - GRID_BITS'(1);
            h_next = h_reg[gi][R_DN];
          end
        end
      end

      always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
          h_reg[gi][gj] <= '0;
          v_reg[gi][gj] <= '0;
        end else if (bus.ram_reset) begin
          h_reg[gi][gj] <= '0;
          v_reg[gi][gj] <= '0;
        end else if (state_reg == SHIFT) begin
          h_reg[gi][gj] <= h_next;
          v_reg[gi][gj] <= v_next;
        end
      end

      assign cell_nonzero[gi*N + gj] = |{h_reg[gi][gj], v_reg[gi][gj]};
    end
  end

  assign bus.offset_y        = h_reg[bus.offset_pos_x][bus.offset_pos_y];
  assign bus.offset_x        = v_reg[bus.offset_pos_x][bus.offset_pos_y];
  assign bus.offset_all_zero = all_zero_reg;
  assign bus.busy            = busy_reg;
endmodule
